// File: rtl/cp0_reg.sv
`timescale 1ns/1ps
// Purpose: CP0 register file (Status/Cause/EPC/BadVAddr/Count/Compare/EBase/PRId) updated from MEM-stage commits.
// Latency: MTC0 and exception/ERET updates land on the next rising edge; rdata_o is combinational, no write bypass.
// Backpressure: none; every commit presented is absorbed in the same cycle.
// Ports: clk/rst (sync, active-high); we_i/waddr_i/wsel_i/wdata_i MTC0 write; raddr_i/rsel_i/rdata_o MFC0 read;
//   int_i level interrupts; exception_* plus inst/delay-slot/badvaddr describe the committing exception or ERET;
//   status_o..badvaddr_o expose register state; timer_int_o is the Count==Compare interrupt.
module cp0_reg #(
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
  parameter logic [31:0] EBASE_RESET  = 32'h8000_0000,
  parameter logic [31:0] PRID_VAL     = 32'h0000_4220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [2:0]  wsel_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  input  logic [2:0]  rsel_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic        exception_flag_i,
  input  logic [4:0]  exception_type_i,
  input  logic        exception_first_inst_i,
  input  logic [31:0] inst1_addr_i,
  input  logic [31:0] inst2_addr_i,
  input  logic        is_in_delayslot1_i,
  input  logic        is_in_delayslot2_i,
  input  logic [31:0] badvaddr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] ebase_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0]  EXC_ADEL = 5'h04;
  localparam logic [4:0]  EXC_ADES = 5'h05;
  localparam logic [4:0]  EXC_ERET = 5'h0e;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] EBASE_WMASK  = 32'h3fff_f000;

  logic [31:0] status_q, cause_q, epc_q, ebase_q, count_q, compare_q, badvaddr_q;
  logic        tick_q, timer_int_q;
  logic [31:0] status_d, cause_d, epc_d, ebase_d, count_d, compare_d, badvaddr_d;
  logic        tick_d, timer_int_d;

  logic        wr_en, wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase;
  logic        is_exc, is_eret, exc_bd;
  logic [31:0] exc_pc;

  // A pipe-1 exception kills the pipe-1 MTC0; a pipe-2 exception does not.
  assign wr_en      = we_i && !(exception_flag_i && exception_first_inst_i);
  assign wr_count   = wr_en && waddr_i == 5'd9  && wsel_i == 3'd0;
  assign wr_compare = wr_en && waddr_i == 5'd11 && wsel_i == 3'd0;
  assign wr_status  = wr_en && waddr_i == 5'd12 && wsel_i == 3'd0;
  assign wr_cause   = wr_en && waddr_i == 5'd13 && wsel_i == 3'd0;
  assign wr_epc     = wr_en && waddr_i == 5'd14 && wsel_i == 3'd0;
  assign wr_ebase   = wr_en && waddr_i == 5'd15 && wsel_i == 3'd1;

  assign is_eret = exception_flag_i && exception_type_i == EXC_ERET;
  assign is_exc  = exception_flag_i && exception_type_i != EXC_ERET;
  assign exc_pc  = exception_first_inst_i ? inst1_addr_i : inst2_addr_i;
  assign exc_bd  = exception_first_inst_i ? is_in_delayslot1_i : is_in_delayslot2_i;

  always_comb begin
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    ebase_d     = ebase_q;
    count_d     = count_q;
    compare_d   = compare_q;
    badvaddr_d  = badvaddr_q;
    tick_d      = ~tick_q;
    timer_int_d = timer_int_q || (compare_q != 32'd0 && count_q == compare_q);

    // Count advances on every other edge; a write restarts the half-rate phase.
    if (wr_count) begin
      count_d = wdata_i;
      tick_d  = 1'b0;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end

    // Writing Compare acknowledges the timer, beating a coincident new match.
    if (wr_compare) begin
      compare_d   = wdata_i;
      timer_int_d = 1'b0;
    end

    if (wr_status) status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
    if (wr_cause)  cause_d[9:8] = wdata_i[9:8];
    if (wr_epc)    epc_d = wdata_i;
    if (wr_ebase)  ebase_d = (ebase_q & ~EBASE_WMASK) | (wdata_i & EBASE_WMASK);

    // Hardware-pending bits track the inputs every cycle; IP7 merges the timer.
    cause_d[15:10] = {int_i[5] | timer_int_q, int_i[4:0]};
    cause_d[30]    = timer_int_q;

    // Exception updates come last so they override a same-cycle pipe-2 MTC0.
    if (is_exc) begin
      status_d[1]  = 1'b1;
      cause_d[6:2] = exception_type_i;
      if (!status_q[1]) begin
        epc_d       = exc_bd ? exc_pc - 32'd4 : exc_pc;
        cause_d[31] = exc_bd;
      end
      if (exception_type_i == EXC_ADEL || exception_type_i == EXC_ADES)
        badvaddr_d = badvaddr_i;
    end else if (is_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= STATUS_RESET;
      cause_q     <= 32'd0;
      epc_q       <= 32'd0;
      ebase_q     <= EBASE_RESET;
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      badvaddr_q  <= 32'd0;
      tick_q      <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      ebase_q     <= ebase_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      badvaddr_q  <= badvaddr_d;
      tick_q      <= tick_d;
      timer_int_q <= timer_int_d;
    end
  end

  always_comb begin
    rdata_o = 32'd0;
    case ({raddr_i, rsel_i})
      {5'd8,  3'd0}: rdata_o = badvaddr_q;
      {5'd9,  3'd0}: rdata_o = count_q;
      {5'd11, 3'd0}: rdata_o = compare_q;
      {5'd12, 3'd0}: rdata_o = status_q;
      {5'd13, 3'd0}: rdata_o = cause_q;
      {5'd14, 3'd0}: rdata_o = epc_q;
      {5'd15, 3'd0}: rdata_o = PRID_VAL;
      {5'd15, 3'd1}: rdata_o = ebase_q;
      default:       rdata_o = 32'd0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign ebase_o     = ebase_q;
  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_reg.sv
`timescale 1ns/1ps
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [2:0]  wsel_i, rsel_i;
  logic [31:0] wdata_i, rdata_o;
  logic [5:0]  int_i;
  logic        exception_flag_i, exception_first_inst_i;
  logic [4:0]  exception_type_i;
  logic [31:0] inst1_addr_i, inst2_addr_i, badvaddr_i;
  logic        is_in_delayslot1_i, is_in_delayslot2_i;
  logic [31:0] status_o, cause_o, epc_o, ebase_o, count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

  always #5 clk = ~clk;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wsel_i(wsel_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rsel_i(rsel_i), .rdata_o(rdata_o), .int_i(int_i),
    .exception_flag_i(exception_flag_i), .exception_type_i(exception_type_i),
    .exception_first_inst_i(exception_first_inst_i),
    .inst1_addr_i(inst1_addr_i), .inst2_addr_i(inst2_addr_i),
    .is_in_delayslot1_i(is_in_delayslot1_i), .is_in_delayslot2_i(is_in_delayslot2_i),
    .badvaddr_i(badvaddr_i), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .ebase_o(ebase_o), .count_o(count_o), .compare_o(compare_o), .badvaddr_o(badvaddr_o),
    .timer_int_o(timer_int_o)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model. Count is kept as "value loaded" plus "edges since load":
  // the architectural count is base + edges/2.
  logic [31:0] m_status, m_cause, m_epc, m_ebase, m_compare, m_badv, m_cnt_base;
  int unsigned m_cnt_n;
  logic        m_timer;

  function automatic logic [31:0] m_count();
    return m_cnt_base + 32'(m_cnt_n / 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s == 3'd0 && a == 5'd8)  return m_badv;
    if (s == 3'd0 && a == 5'd9)  return m_count();
    if (s == 3'd0 && a == 5'd11) return m_compare;
    if (s == 3'd0 && a == 5'd12) return m_status;
    if (s == 3'd0 && a == 5'd13) return m_cause;
    if (s == 3'd0 && a == 5'd14) return m_epc;
    if (s == 3'd0 && a == 5'd15) return 32'h0000_4220;
    if (s == 3'd1 && a == 5'd15) return m_ebase;
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_status = 32'h0040_0000; m_ebase = 32'h8000_0000;
    m_cause = 0; m_epc = 0; m_compare = 0; m_badv = 0;
    m_cnt_base = 0; m_cnt_n = 0; m_timer = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs as currently driven.
  task automatic m_edge();
    logic [31:0] cnt, pc, n_status, n_cause, n_epc, n_compare;
    logic        wr, exl, exc, eret, bd, n_timer, loaded;
    if (rst) begin
      m_reset();
      return;
    end
    cnt = m_count();
    wr   = we_i && !(exception_flag_i && exception_first_inst_i);
    exl  = m_status[1];
    exc  = exception_flag_i && exception_type_i != 5'h0e;
    eret = exception_flag_i && exception_type_i == 5'h0e;
    pc   = exception_first_inst_i ? inst1_addr_i : inst2_addr_i;
    bd   = exception_first_inst_i ? is_in_delayslot1_i : is_in_delayslot2_i;
    n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_compare = m_compare;
    n_timer  = m_timer || (m_compare != 0 && cnt == m_compare);
    loaded   = 1'b0;
    if (wr && wsel_i == 3'd0) begin
      if (waddr_i == 5'd9)  begin m_cnt_base = wdata_i; loaded = 1'b1; end
      if (waddr_i == 5'd11) begin n_compare = wdata_i; n_timer = 1'b0; end
      if (waddr_i == 5'd12) n_status = (m_status & 32'hffff_00fc) | (wdata_i & 32'h0000_ff03);
      if (waddr_i == 5'd13) n_cause[9:8] = wdata_i[9:8];
      if (waddr_i == 5'd14) n_epc = wdata_i;
    end
    if (wr && wsel_i == 3'd1 && waddr_i == 5'd15)
      m_ebase = (m_ebase & 32'hc000_0fff) | (wdata_i & 32'h3fff_f000);
    n_cause[15] = int_i[5] | m_timer;
    n_cause[14:10] = int_i[4:0];
    n_cause[30] = m_timer;
    if (exc) begin
      n_status[1] = 1'b1;
      n_cause[6:2] = exception_type_i;
      if (!exl) begin
        n_epc = bd ? pc - 4 : pc;
        n_cause[31] = bd;
      end
      if (exception_type_i == 5'h04 || exception_type_i == 5'h05) m_badv = badvaddr_i;
    end
    if (eret) n_status[1] = 1'b0;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    m_compare = n_compare; m_timer = n_timer;
    m_cnt_n = loaded ? 0 : m_cnt_n + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("status", status_o, m_status);
    chk("cause", cause_o, m_cause);
    chk("epc", epc_o, m_epc);
    chk("ebase", ebase_o, m_ebase);
    chk("count", count_o, m_count());
    chk("compare", compare_o, m_compare);
    chk("badvaddr", badvaddr_o, m_badv);
    chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
    chk("rdata", rdata_o, m_read(raddr_i, rsel_i));
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic idle();
    rst = 0; we_i = 0; waddr_i = 0; wsel_i = 0; wdata_i = 0; raddr_i = 5'd12; rsel_i = 0;
    int_i = 0; exception_flag_i = 0; exception_type_i = 0; exception_first_inst_i = 0;
    inst1_addr_i = 0; inst2_addr_i = 0; is_in_delayslot1_i = 0; is_in_delayslot2_i = 0;
    badvaddr_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    we_i = 1; waddr_i = a; wsel_i = s; wdata_i = d;
    step();
    we_i = 0;
  endtask

  task automatic raise(input logic [4:0] t, input logic first, input logic [31:0] pc,
                       input logic ds, input logic [31:0] bad);
    exception_flag_i = 1; exception_type_i = t; exception_first_inst_i = first;
    inst1_addr_i = first ? pc : 32'hdead_0000; inst2_addr_i = first ? 32'hdead_0000 : pc;
    is_in_delayslot1_i = first ? ds : 1'b0; is_in_delayslot2_i = first ? 1'b0 : ds;
    badvaddr_i = bad;
    step();
    exception_flag_i = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [2:0] s, input string tag,
                    input logic [31:0] exp);
    raddr_i = a; rsel_i = s;
    #1;
    chk(tag, rdata_o, exp);
  endtask

  logic [4:0] addr_pool [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
  logic [4:0] type_pool [9] = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c, 5'h0d, 5'h0e};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    m_reset();
    rst = 1;
    step(); step();
    rst = 0;
    rd(5'd12, 3'd0, "rst_status", 32'h0040_0000);
    rd(5'd15, 3'd1, "rst_ebase", 32'h8000_0000);
    rd(5'd14, 3'd0, "rst_epc", 32'h0000_0000);
    rd(5'd15, 3'd0, "prid", 32'h0000_4220);
    chk("rst_timer", {31'd0, timer_int_o}, 32'd0);

    // Timer: Count=0, Compare=5, wait for the match.
    mtc0(5'd9, 3'd0, 32'd0);
    mtc0(5'd11, 3'd0, 32'd5);
    for (int i = 0; i < 30 && !timer_int_o; i++) step();
    chk("timer_rise", {31'd0, timer_int_o}, 32'd1);
    step();
    chk("cause_ip7", {31'd0, cause_o[15]}, 32'd1);
    chk("cause_ti", {31'd0, cause_o[30]}, 32'd1);
    mtc0(5'd11, 3'd0, 32'd9);
    chk("timer_ack", {31'd0, timer_int_o}, 32'd0);

    // Pipe-2 overflow in a delay slot.
    raise(5'h0c, 1'b0, 32'hbfc0_0104, 1'b1, 32'd0);
    chk("ov_epc", epc_o, 32'hbfc0_0100);
    chk("ov_bd", {31'd0, cause_o[31]}, 32'd1);
    chk("ov_exccode", {27'd0, cause_o[6:2]}, 32'h0c);
    chk("ov_exl", {31'd0, status_o[1]}, 32'd1);
    raise(5'h0e, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("eret1_exl", {31'd0, status_o[1]}, 32'd0);

    // Pipe-1 MTC0 EPC with a pipe-2 syscall: the exception owns EPC.
    we_i = 1; waddr_i = 5'd14; wsel_i = 0; wdata_i = 32'h0000_1234;
    raise(5'h08, 1'b0, 32'hbfc0_0200, 1'b0, 32'd0);
    we_i = 0;
    chk("sys_epc", epc_o, 32'hbfc0_0200);
    raise(5'h0e, 1'b0, 32'd0, 1'b0, 32'd0);

    // Pipe-1 AdEL kills its own MTC0 Compare.
    we_i = 1; waddr_i = 5'd11; wsel_i = 0; wdata_i = 32'd77;
    raise(5'h04, 1'b1, 32'hbfc0_0300, 1'b0, 32'h0000_1003);
    we_i = 0;
    chk("adel_cmp_kept", compare_o, 32'd9);
    chk("adel_badv", badvaddr_o, 32'h0000_1003);
    chk("adel_epc", epc_o, 32'hbfc0_0300);

    // Nested exception while EXL=1, then ERET.
    raise(5'h0a, 1'b1, 32'hbfc0_0400, 1'b1, 32'd0);
    chk("nest_epc", epc_o, 32'hbfc0_0300);
    chk("nest_exccode", {27'd0, cause_o[6:2]}, 32'h0a);
    raise(5'h0e, 1'b1, 32'd0, 1'b0, 32'd0);
    chk("eret2_exl", {31'd0, status_o[1]}, 32'd0);
    chk("eret2_epc", epc_o, 32'hbfc0_0300);

    // Only IP1:IP0 of Cause are software-writable.
    mtc0(5'd13, 3'd0, 32'hffff_ffff);
    chk("cause_ip_sw", {30'd0, cause_o[9:8]}, 32'd3);
    chk("cause_exc_kept", {27'd0, cause_o[6:2]}, 32'h0a);
    chk("cause_bd_kept", {31'd0, cause_o[31]}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      we_i = ($urandom % 3) == 0;
      waddr_i = addr_pool[$urandom % 8];
      wsel_i = (waddr_i == 5'd15) ? 3'($urandom % 2) : (($urandom % 8) == 0 ? 3'd1 : 3'd0);
      wdata_i = $urandom;
      if (waddr_i == 5'd11 && ($urandom % 2) == 0) wdata_i = m_count() + $urandom_range(1, 20);
      if (waddr_i == 5'd9 && ($urandom % 2) == 0) wdata_i = 32'hffff_fff0 + $urandom_range(0, 15);
      raddr_i = addr_pool[$urandom % 8];
      rsel_i = (raddr_i == 5'd15) ? 3'($urandom % 2) : 3'd0;
      int_i = 6'($urandom);
      exception_flag_i = ($urandom % 5) == 0;
      exception_type_i = type_pool[$urandom % 9];
      exception_first_inst_i = 1'($urandom);
      inst1_addr_i = $urandom & 32'hffff_fffc;
      inst2_addr_i = $urandom & 32'hffff_fffc;
      is_in_delayslot1_i = 1'($urandom);
      is_in_delayslot2_i = 1'($urandom);
      badvaddr_i = $urandom;
      step();
    end

    // Reset in the middle of counting.
    idle();
    mtc0(5'd9, 3'd0, 32'h0000_1000);
    int_i = 6'h3f;
    step(); step(); step();
    rst = 1;
    step();
    rst = 0;
    chk("mrst_status", status_o, 32'h0040_0000);
    chk("mrst_count", count_o, 32'd0);
    chk("mrst_cause", cause_o, 32'd0);
    chk("mrst_epc", epc_o, 32'd0);
    chk("mrst_ebase", ebase_o, 32'h8000_0000);
    chk("mrst_badv", badvaddr_o, 32'd0);
    chk("mrst_timer", {31'd0, timer_int_o}, 32'd0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
